// File: rtl/hsv2rgb.sv
// hsv2rgb: six-stage pipelined HSV-to-RGB converter, 8 bits per channel.
// Every division by 255 is done with shift-add, so there are no dividers.
// A sideband word and a valid flag move through the pipe with the pixel.
module hsv2rgb #(
  parameter int SIDEBAND_W = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [7:0]            h,
  input  logic [7:0]            s,
  input  logic [7:0]            v,
  input  logic [SIDEBAND_W-1:0] in_side,
  output logic                  out_valid,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic [SIDEBAND_W-1:0] out_side
);

  // floor(x/255) for 0 <= x <= 65025, computed as (x + 1 + (x >> 8)) >> 8.
  // The sum is at most 65280, so the 17-bit sum never overflows.
  function automatic logic [7:0] div255(input logic [15:0] x);
    logic [16:0] sum;
    sum = {1'b0, x} + 17'd1 + {9'd0, x[15:8]};
    return 8'(sum >> 8);
  endfunction

  // Stage 1: registered input pixel, with the hue scaled by 6
  logic [10:0]           hx6_1;
  logic [7:0]            s_1, v_1;
  logic [SIDEBAND_W-1:0] side_1;

  // Stage 2: sector index and the three products
  logic [2:0]            sector_2;
  logic [15:0]           a_2, b_2, c_2;
  logic [7:0]            v_2;
  logic [SIDEBAND_W-1:0] side_2;

  // Stage 3: s*f/255, s*(255-f)/255, and the floor channel p
  logic [2:0]            sector_3;
  logic [7:0]            sf_3, sfi_3, p_3, v_3;
  logic [SIDEBAND_W-1:0] side_3;

  // Stage 4: products for the falling (q) and rising (t) channels
  logic [2:0]            sector_4;
  logic [15:0]           d_4, e_4;
  logic [7:0]            p_4, v_4;
  logic [SIDEBAND_W-1:0] side_4;

  // Stage 5: every channel candidate, each already within 0..255
  logic [2:0]            sector_5;
  logic [7:0]            q_5, t_5, p_5, v_5;
  logic [SIDEBAND_W-1:0] side_5;

  // Valid flags for stages 1 to 5. out_valid is the stage 6 flag.
  logic [5:1]            valid_pipe;

  // Combinational output mux that feeds the stage 6 registers
  logic [7:0]            r_mux, g_mux, b_mux;

  // Shift the valid flag along the pipe. Reset clears every pixel still in flight.
  // NOTE: sequential state uses non-blocking assignments, so all stages update
  // together from their values before the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_pipe <= '0;
      out_valid  <= 1'b0;
    end else if (enable) begin
      valid_pipe <= {valid_pipe[4:1], in_valid};
      out_valid  <= valid_pipe[5];
    end
  end

  // Datapath registers load on every enabled cycle, whether or not the pixel is valid
  // NOTE: the datapath registers have no reset. The valid pipe already marks
  // stale data, so a reset here would only add fanout on reset_n.
  always_ff @(posedge clock) begin
    if (enable) begin
      hx6_1    <= 11'(h) * 11'd6;
      s_1      <= s;
      v_1      <= v;
      side_1   <= in_side;

      sector_2 <= hx6_1[10:8];
      a_2      <= 16'(s_1) * 16'(hx6_1[7:0]);
      b_2      <= 16'(s_1) * 16'(8'd255 - hx6_1[7:0]);
      c_2      <= 16'(v_1) * 16'(8'd255 - s_1);
      v_2      <= v_1;
      side_2   <= side_1;

      sector_3 <= sector_2;
      sf_3     <= div255(a_2);
      sfi_3    <= div255(b_2);
      p_3      <= div255(c_2);
      v_3      <= v_2;
      side_3   <= side_2;

      sector_4 <= sector_3;
      d_4      <= 16'(v_3) * 16'(8'd255 - sf_3);
      e_4      <= 16'(v_3) * 16'(8'd255 - sfi_3);
      p_4      <= p_3;
      v_4      <= v_3;
      side_4   <= side_3;

      sector_5 <= sector_4;
      q_5      <= div255(d_4);
      t_5      <= div255(e_4);
      p_5      <= p_4;
      v_5      <= v_4;
      side_5   <= side_4;
    end
  end

  // Route the candidates to r/g/b by sector. Sectors 6 and 7 cannot occur and decode as sector 0.
  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    r_mux = v_5;
    g_mux = t_5;
    b_mux = p_5;
    case (sector_5)
      3'd1: begin r_mux = q_5; g_mux = v_5; b_mux = p_5; end
      3'd2: begin r_mux = p_5; g_mux = v_5; b_mux = t_5; end
      3'd3: begin r_mux = p_5; g_mux = q_5; b_mux = v_5; end
      3'd4: begin r_mux = t_5; g_mux = p_5; b_mux = v_5; end
      3'd5: begin r_mux = v_5; g_mux = p_5; b_mux = q_5; end
      default: ;
    endcase
  end

  // Stage 6: registered outputs, cleared by reset and held while enable is low
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r        <= '0;
      g        <= '0;
      b        <= '0;
      out_side <= '0;
    end else if (enable) begin
      r        <= r_mux;
      g        <= g_mux;
      b        <= b_mux;
      out_side <= side_5;
    end
  end

endmodule

// File: tb/tb_hsv2rgb.sv
// tb_hsv2rgb: self-checking bench for hsv2rgb.
// A scoreboard fed from a reference model in plain integer arithmetic checks every output beat.
// Directed steps check the known colours, a hue sweep, stalls, a mid-stream reset and random pixels.
module tb_hsv2rgb;

  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    h = '0, s = '0, v = '0;
  logic [SW-1:0] in_side = '0;
  logic          out_valid;
  logic [7:0]    r, g, b;
  logic [SW-1:0] out_side;

  int checks = 0;
  int errors = 0;

  hsv2rgb #(.SIDEBAND_W(SW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .in_valid (in_valid),
    .h        (h),
    .s        (s),
    .v        (v),
    .in_side  (in_side),
    .out_valid(out_valid),
    .r        (r),
    .g        (g),
    .b        (b),
    .out_side (out_side)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion. True integer division stands in for the shift-add /255.
  function automatic logic [23:0] ref_rgb(input int hh, input int ss, input int vv);
    int hx6, sector, f, sf, sfi, p, q, t, rr, gg, bb;
    hx6    = hh * 6;
    sector = hx6 / 256;
    f      = hx6 % 256;
    sf     = (ss * f) / 255;
    sfi    = (ss * (255 - f)) / 255;
    p      = (vv * (255 - ss)) / 255;
    q      = (vv * (255 - sf)) / 255;
    t      = (vv * (255 - sfi)) / 255;
    case (sector)
      1:       begin rr = q;  gg = vv; bb = p;  end
      2:       begin rr = p;  gg = vv; bb = t;  end
      3:       begin rr = p;  gg = q;  bb = vv; end
      4:       begin rr = t;  gg = p;  bb = vv; end
      5:       begin rr = vv; gg = p;  bb = q;  end
      default: begin rr = vv; gg = t;  bb = p;  end
    endcase
    return {8'(rr), 8'(gg), 8'(bb)};
  endfunction

  typedef struct {
    logic [23:0]   rgb;
    logic [SW-1:0] side;
    int            tick;
  } exp_t;

  exp_t    sb[$];
  int      tick = 0;
  bit      en_q = 0, rst_q = 0;
  logic [24+SW:0] held;

  // On each edge, note enable/reset and queue the expected result of any pixel accepted
  always @(posedge clock) begin
    en_q  = enable;
    rst_q = reset_n;
    if (!reset_n) sb.delete();
    else if (enable) begin
      tick++;
      if (in_valid) sb.push_back('{ref_rgb(h, s, v), in_side, tick});
    end
  end

  // Half a cycle after each edge, check reset, hold or the scoreboard, whichever applies
  always @(negedge clock) begin
    if (!rst_q) begin
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_rgb", {8'd0, r, g, b}, 0);
      check("reset_side", 32'(out_side), 0);
    end else if (!en_q) begin
      check("stall_hold", 32'({out_valid, r, g, b, out_side}), 32'(held));
    end else if (out_valid) begin
      check("no_stale_pixel", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("stream_rgb", {8'd0, r, g, b}, {8'd0, e.rgb});
        check("stream_side", 32'(out_side), 32'(e.side));
        check("stream_latency", 32'(tick - e.tick + 1), 6);
      end
    end
    held = {out_valid, r, g, b, out_side};
  end

  task automatic drive(input bit en, input bit vld, input logic [7:0] hh, input logic [7:0] ss,
                       input logic [7:0] vv, input logic [SW-1:0] sd);
    enable   = en;
    in_valid = vld;
    h        = hh;
    s        = ss;
    v        = vv;
    in_side  = sd;
    @(posedge clock);
    #1;
  endtask

  // Send one pixel, idle five cycles, then compare against a known colour
  task automatic directed(input string tag, input logic [7:0] hh, input logic [7:0] ss,
                          input logic [7:0] vv, input logic [23:0] exp);
    drive(1, 1, hh, ss, vv, 8'hA5);
    repeat (5) drive(1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check(tag, {8'd0, r, g, b}, {8'd0, exp});
    #1;
  endtask

  initial begin
    // Reset for two cycles
    reset_n = 1'b0;
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0);

    // Known colours
    directed("red",     8'd0,   8'd255, 8'd255, 24'hFF0000);
    directed("green",   8'd85,  8'd255, 8'd255, 24'h01FF00);
    directed("blue",    8'd170, 8'd255, 8'd255, 24'h0003FF);
    directed("yellow",  8'd43,  8'd255, 8'd255, 24'hFDFF00);
    directed("grey",    8'd200, 8'd0,   8'd128, 24'h808080);
    directed("black",   8'($urandom), 8'($urandom), 8'd0, 24'h000000);
    directed("white",   8'd255, 8'd0,   8'd255, 24'hFFFFFF);

    // Back-to-back hue sweep, sideband = index
    for (int i = 0; i < 256; i++) drive(1, 1, 8'(i), 8'd255, 8'd255, 8'(i));
    repeat (8) drive(1, 0, 0, 0, 0, 0);
    check("sweep_drained", 32'(sb.size()), 0);

    // Random pixels with pseudo-random stalls and gaps
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (8) drive(1, 0, 0, 0, 0, 0);
    check("random_drained", 32'(sb.size()), 0);

    // Mid-stream reset with four pixels in flight
    for (int i = 0; i < 4; i++) drive(1, 1, 8'($urandom), 8'd200, 8'd200, 8'(i));
    reset_n = 1'b0;
    drive(1, 1, 8'd10, 8'd10, 8'd10, 8'hEE);
    reset_n = 1'b1;
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    check("after_reset_no_valid", 32'(out_valid), 0);
    directed("after_reset_pixel", 8'd0, 8'd255, 8'd255, 24'hFF0000);
    repeat (8) drive(1, 0, 0, 0, 0, 0);
    check("reset_drained", 32'(sb.size()), 0);

    // Wide random run, free-flowing
    for (int i = 0; i < 4000; i++)
      drive(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (8) drive(1, 0, 0, 0, 0, 0);
    check("final_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
